rr_sel_arbiter: RTL and testbench
=================================

RR_SEL_ARBITER -- requirements
Module: rr_sel_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  per-input flit-valid request; bit i = crossbar input i.
REQ-005 tail  input  4  bit i = flit on input i is last flit of its packet; single-flit packets have tail=1.
REQ-006 out_ready  input  1  downstream output-port register accepts a flit this cycle.
REQ-007 sel  output  2  registered select driving the 4:1 crossbar mux for this output port.
REQ-008 sel_valid  output  1  registered; sel carries a granted flit this cycle.
REQ-009 grant  output  4  registered one-hot grant back to inputs; equals onehot(sel) when sel_valid=1, else 0.

Function
REQ-010 All outputs SHALL be registered; a decision made from req/tail at edge t SHALL appear on sel/sel_valid/grant after edge t.
REQ-011 State SHALL be IDLE or LOCKED, plus a 2-bit round-robin pointer ptr and a 2-bit owner.
REQ-012 Winner selection SHALL be a rotating priority search over req starting at index ptr, then ptr+1, ptr+2 and ptr+3 (mod 4); the first set bit wins.
REQ-013 On an edge with out_ready=1 in IDLE and req!=0: sel<=winner w, grant<=onehot(w), sel_valid<=1.
REQ-014 In the REQ-013 case, if tail[w]=1: remain IDLE and ptr<=w+1 mod 4.
REQ-015 In the REQ-013 case, if tail[w]=0: go to LOCKED, owner<=w, and leave ptr unchanged.
REQ-016 On an edge with out_ready=1 in IDLE and req=0: sel_valid<=0 and grant<=0; sel, ptr and state SHALL hold.
REQ-017 On an edge with out_ready=1 in LOCKED and req[owner]=1: sel<=owner, grant<=onehot(owner), sel_valid<=1; requests from other inputs are ignored.
REQ-018 In the REQ-017 case, if tail[owner]=1: go to IDLE and ptr<=owner+1 mod 4.
REQ-019 On an edge with out_ready=1 in LOCKED and req[owner]=0 (bubble): sel_valid<=0 and grant<=0, stay LOCKED, and sel, owner and ptr SHALL hold.
REQ-020 On any edge with out_ready=0: all registers (sel, sel_valid, grant, state, ptr, owner) SHALL hold their values.
REQ-021 Pointer wrap SHALL be modulo 4: ptr=3 followed by a win by input 3 gives ptr=0.
REQ-022 All-four-requesting with ptr=2 SHALL grant input 2, not input 0.
REQ-023 grant SHALL never have more than one bit set; sel_valid=0 SHALL imply grant=0.

Reset
REQ-024 While reset=1, asynchronously: sel=0, sel_valid=0, grant=0, state=IDLE, ptr=0, owner=0.
REQ-025 Reset asserted mid-packet (LOCKED) SHALL abandon the lock; the first post-reset grant SHALL follow IDLE rules with ptr=0.
REQ-026 Reset SHALL override out_ready and req.

Structure
REQ-027 The shared package SHALL hold NUM_IN=4, SEL_W=2 and the IDLE/LOCKED state encoding.
REQ-028 The rotating priority search SHALL be a combinational sub-module rr_priority_pick (inputs req[3:0] and ptr[1:0]; outputs winner[1:0] and any).
REQ-029 The block SHALL contain no flit datapath; the flit data stays in the crossbar mux.

Verification
REQ-030 Reset, then req=4'b0001 with tail=4'b0001 and out_ready=1 for one cycle -> next cycle sel=0, sel_valid=1, grant=0001; ptr becomes 1.
REQ-031 req=4'b1111 with tail=4'b1111 held for 5 cycles from ptr=0 -> sel sequence 0,1,2,3,0 and ptr wraps to 1.
REQ-032 3-flit packet on input 2 (tail only on flit 3) with req=4'b1111 throughout -> sel=2 for 3 consecutive valid cycles, then sel=3.
REQ-033 In LOCKED (owner=1), drop req[1] for 2 cycles with req[0]=1 -> sel_valid=0 and grant=0 for 2 cycles, then sel=1 resumes; input 0 is not granted.
REQ-034 Hold out_ready=0 for 3 cycles mid-stream -> sel, sel_valid, grant and ptr are unchanged across those cycles.
REQ-035 Assert reset while LOCKED (owner=3) -> outputs 0 immediately; after release, req=4'b1000 with tail=1 -> sel=3, sel_valid=1, ptr becomes 0.

Source files
------------

// File: rtl/rr_sel_arbiter_pkg.sv
// Shared types and constants for the 4-input round-robin select arbiter.
package rr_sel_arbiter_pkg;

   localparam int unsigned NUM_IN = 4;
   localparam int unsigned SEL_W  = 2;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   // Registered view of the crossbar select bus
   typedef struct packed {
      logic [SEL_W-1:0]  sel;
      logic              sel_valid;
      logic [NUM_IN-1:0] grant;
   } sel_out_t;

   function automatic logic [NUM_IN-1:0] onehot(input logic [SEL_W-1:0] idx);
      onehot = NUM_IN'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// Request/select bus between crossbar inputs and the output-port arbiter.
interface rr_sel_arbiter_if;
   import rr_sel_arbiter_pkg::*;

   logic [NUM_IN-1:0] req;
   logic [NUM_IN-1:0] tail;
   logic              out_ready;
   logic [SEL_W-1:0]  sel;
   logic              sel_valid;
   logic [NUM_IN-1:0] grant;

   modport master (
      input  req,
      input  tail,
      input  out_ready,
      output sel,
      output sel_valid,
      output grant
   );

   modport slave (
      output req,
      output tail,
      output out_ready,
      input  sel,
      input  sel_valid,
      input  grant
   );

endinterface

// File: rtl/rr_priority_pick.sv
// Rotating priority search: first set request bit at or after ptr, modulo NUM_IN.
module rr_priority_pick
   import rr_sel_arbiter_pkg::*;
(
   input  logic [NUM_IN-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [SEL_W-1:0]  winner,
   output logic              any
);

   logic [SEL_W-1:0] idx;

   always_comb begin
      winner = '0;
      any    = 1'b0;
      idx    = '0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         idx = SEL_W'(ptr + SEL_W'(k));
         if (!any && req[idx]) begin
            winner = idx;
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Output-port arbiter: round-robin between 4 crossbar inputs, held for a whole packet.
module rr_sel_arbiter
   import rr_sel_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   rr_sel_arbiter_if.master  bus
);

   arb_state_e       state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] owner_q, owner_d;
   sel_out_t         out_q, out_d;

   logic [SEL_W-1:0] winner_c;
   logic             any_c;

   rr_priority_pick u_pick (
      .req    (bus.req),
      .ptr    (ptr_q),
      .winner (winner_c),
      .any    (any_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         out_q   <= out_d;
      end
   end

   // Everything holds unless the downstream register accepts this cycle
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      out_d   = out_q;
      if (bus.out_ready) begin
         case (state_q)
            ST_IDLE: begin
               if (any_c) begin
                  out_d.sel       = winner_c;
                  out_d.sel_valid = 1'b1;
                  out_d.grant     = onehot(winner_c);
                  if (bus.tail[winner_c]) begin
                     ptr_d = SEL_W'(winner_c + SEL_W'(1));
                  end else begin
                     state_d = ST_LOCKED;
                     owner_d = winner_c;
                  end
               end else begin
                  out_d.sel_valid = 1'b0;
                  out_d.grant     = '0;
               end
            end
            ST_LOCKED: begin
               // Only the owner may advance; other inputs wait for the tail
               if (bus.req[owner_q]) begin
                  out_d.sel       = owner_q;
                  out_d.sel_valid = 1'b1;
                  out_d.grant     = onehot(owner_q);
                  if (bus.tail[owner_q]) begin
                     state_d = ST_IDLE;
                     ptr_d   = SEL_W'(owner_q + SEL_W'(1));
                  end
               end else begin
                  out_d.sel_valid = 1'b0;
                  out_d.grant     = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign bus.sel       = out_q.sel;
   assign bus.sel_valid = out_q.sel_valid;
   assign bus.grant     = out_q.grant;

   a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
      $onehot0(bus.grant) && (bus.sel_valid || (bus.grant == '0)));

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter: hand-computed sel/sel_valid/grant per cycle.
module tb_rr_sel_arbiter;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   rr_sel_arbiter_if bus_if ();

   rr_sel_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] ex(input int s, input int v);
      logic [1:0] s2;
      logic       v2;
      logic [3:0] g;
      s2 = 2'(s);
      v2 = (v != 0);
      g  = v2 ? (4'b0001 << s2) : 4'b0000;
      return {s2, v2, g};
   endfunction

   function automatic logic [6:0] obs();
      return {bus_if.sel, bus_if.sel_valid, bus_if.grant};
   endfunction

   task automatic drive(input logic [3:0] r, input logic [3:0] t, input logic rdy);
      bus_if.req       = r;
      bus_if.tail      = t;
      bus_if.out_ready = rdy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(4'b0000, 4'b0000, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [6:0] o;
      reset = 1'b1;
      drive(4'b0000, 4'b0000, 1'b0);
      step();
      step();
      o = obs();
      n_checks++;
      if (o !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_state: got %b exp %b", o, 7'b0);
      end
      drive(4'b1111, 4'b1111, 1'b1);
      step();
      o = obs();
      n_checks++;
      if (o !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_overrides_req: got %b exp %b", o, 7'b0);
      end
      reset = 1'b0;
   endtask

   task automatic test_single();
      logic [6:0] o;
      logic [6:0] e [3];
      logic [3:0] rq [3];
      e[0] = ex(0, 1); rq[0] = 4'b0001;
      e[1] = ex(1, 1); rq[1] = 4'b0011;
      e[2] = ex(1, 0); rq[2] = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         drive(rq[i], rq[i], 1'b1);
         step();
         o = obs();
         n_checks++;
         if (o !== e[i]) begin
            n_fail++;
            $display("FAIL single_flit[%0d]: got %b exp %b", i, o, e[i]);
         end
      end
   endtask

   task automatic test_rotate();
      logic [6:0] o;
      int exp_sel [9];
      logic [3:0] rq [9];
      exp_sel = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
      for (int i = 0; i < 9; i++) rq[i] = 4'b1111;
      rq[7] = 4'b1000;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(rq[i], rq[i], 1'b1);
         step();
         o = obs();
         n_checks++;
         if (o !== ex(exp_sel[i], 1)) begin
            n_fail++;
            $display("FAIL rotate[%0d]: got %b exp %b", i, o, ex(exp_sel[i], 1));
         end
      end
   endtask

   task automatic test_packet();
      logic [6:0] o;
      logic [3:0] rq [5];
      logic [3:0] tl [5];
      int         es [5];
      rq = '{4'b0010, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
      tl = '{4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b1111};
      es = '{1, 2, 2, 2, 3};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(rq[i], tl[i], 1'b1);
         step();
         o = obs();
         n_checks++;
         if (o !== ex(es[i], 1)) begin
            n_fail++;
            $display("FAIL packet_lock[%0d]: got %b exp %b", i, o, ex(es[i], 1));
         end
      end
   endtask

   task automatic test_bubble();
      logic [6:0] o;
      logic [3:0] rq [5];
      logic [3:0] tl [5];
      logic [6:0] e  [5];
      rq = '{4'b0010, 4'b0001, 4'b0001, 4'b0011, 4'b0011};
      tl = '{4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0011};
      e  = '{ex(1, 1), ex(1, 0), ex(1, 0), ex(1, 1), ex(0, 1)};
      for (int i = 0; i < 5; i++) begin
         drive(rq[i], tl[i], 1'b1);
         step();
         o = obs();
         n_checks++;
         if (o !== e[i]) begin
            n_fail++;
            $display("FAIL bubble[%0d]: got %b exp %b", i, o, e[i]);
         end
      end
   endtask

   task automatic test_stall();
      logic [6:0] o;
      logic [3:0] rq [5];
      logic       rd [5];
      logic [6:0] e  [5];
      rq = '{4'b1111, 4'b0100, 4'b1000, 4'b0001, 4'b1111};
      rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      e  = '{ex(1, 1), ex(1, 1), ex(1, 1), ex(1, 1), ex(2, 1)};
      for (int i = 0; i < 5; i++) begin
         drive(rq[i], rq[i], rd[i]);
         step();
         o = obs();
         n_checks++;
         if (o !== e[i]) begin
            n_fail++;
            $display("FAIL stall[%0d]: got %b exp %b", i, o, e[i]);
         end
      end
   endtask

   task automatic test_reset_locked();
      logic [6:0] o;
      drive(4'b1000, 4'b0000, 1'b1);
      step();
      step();
      o = obs();
      n_checks++;
      if (o !== ex(3, 1)) begin
         n_fail++;
         $display("FAIL locked_owner3: got %b exp %b", o, ex(3, 1));
      end
      drive(4'b1111, 4'b1111, 1'b1);
      reset = 1'b1;
      #1;
      o = obs();
      n_checks++;
      if (o !== 7'b0) begin
         n_fail++;
         $display("FAIL async_reset: got %b exp %b", o, 7'b0);
      end
      step();
      o = obs();
      n_checks++;
      if (o !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_held: got %b exp %b", o, 7'b0);
      end
      reset = 1'b0;
      drive(4'b1000, 4'b1000, 1'b1);
      step();
      o = obs();
      n_checks++;
      if (o !== ex(3, 1)) begin
         n_fail++;
         $display("FAIL post_reset_grant: got %b exp %b", o, ex(3, 1));
      end
      drive(4'b1111, 4'b1111, 1'b1);
      step();
      o = obs();
      n_checks++;
      if (o !== ex(0, 1)) begin
         n_fail++;
         $display("FAIL post_reset_wrap: got %b exp %b", o, ex(0, 1));
      end
      // Lock on input 2, reset, then only input 0 requests: must not bubble
      drive(4'b0100, 4'b0000, 1'b1);
      step();
      o = obs();
      n_checks++;
      if (o !== ex(2, 1)) begin
         n_fail++;
         $display("FAIL relock_owner2: got %b exp %b", o, ex(2, 1));
      end
      do_reset();
      drive(4'b0001, 4'b0001, 1'b1);
      step();
      o = obs();
      n_checks++;
      if (o !== ex(0, 1)) begin
         n_fail++;
         $display("FAIL lock_abandoned: got %b exp %b", o, ex(0, 1));
      end
   endtask

   initial begin
      clk      = 1'b0;
      reset    = 1'b1;
      n_checks = 0;
      n_fail   = 0;
      drive(4'b0000, 4'b0000, 1'b0);
      test_reset();
      test_single();
      test_rotate();
      test_packet();
      test_bubble();
      test_stall();
      test_reset_locked();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
